// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall sequencer for the pipelined RISC-V core: resolves cache misses,
// taken branches/jumps and load-use hazards, and counts stalled cycles.
module pipe_hazard_ctrl #(
    parameter int MISS_SRCS   = 2,
    parameter int FLUSH_SLOTS = 1,
    parameter int LOAD_USE_EN = 1,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          id_instr,
    input  logic                 id_valid,
    input  logic                 ex_valid,
    input  logic                 ex_is_load,
    input  logic [4:0]           ex_rd,
    input  logic                 br_taken,
    input  logic [MISS_SRCS-1:0] miss,
    input  logic [MISS_SRCS-1:0] fill_done,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 if_id_flush,
    output logic                 id_ex_en,
    output logic                 id_ex_flush,
    output logic                 miss_busy,
    output logic [MISS_SRCS-1:0] pending,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef enum logic [1:0] {RUN, MISS_WAIT, FLUSH} state_t;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_SLOTS - 2);

    state_t               state_reg, state_next;
    logic [MISS_SRCS-1:0] pending_reg, pending_next;
    logic [1:0]           flush_left_reg, flush_left_next;
    logic [CNT_W-1:0]     stall_cnt_reg;

    logic       pc_en_int, if_id_en_int, id_ex_en_int;
    logic       if_id_flush_int, id_ex_flush_int;
    logic [6:0] opcode;
    logic [4:0] rs1, rs2;
    logic       rs1_used, rs2_used, load_use;

    assign opcode = id_instr[6:0];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];

    assign rs1_used = (opcode == OP_REG) || (opcode == OP_IMM) || (opcode == OP_LOAD) ||
                      (opcode == OP_BRANCH) || (opcode == OP_STORE) || (opcode == OP_JALR);
    assign rs2_used = (opcode == OP_REG) || (opcode == OP_BRANCH) || (opcode == OP_STORE);

    assign load_use = (LOAD_USE_EN != 0) && id_valid && ex_valid && ex_is_load &&
                      (ex_rd != 5'd0) &&
                      ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));

    always_comb begin
        state_next      = state_reg;
        pending_next    = pending_reg;
        flush_left_next = flush_left_reg;
        pc_en_int       = 1'b1;
        if_id_en_int    = 1'b1;
        id_ex_en_int    = 1'b1;
        if_id_flush_int = 1'b0;
        id_ex_flush_int = 1'b0;
        case (state_reg)
            RUN: begin
                if (|miss) begin
                    pc_en_int    = 1'b0;
                    if_id_en_int = 1'b0;
                    id_ex_en_int = 1'b0;
                    pending_next = miss;
                    state_next   = MISS_WAIT;
                end else if (br_taken) begin
                    if_id_flush_int = 1'b1;
                    id_ex_flush_int = 1'b1;
                    if (FLUSH_SLOTS > 1) begin
                        flush_left_next = FLUSH_INIT;
                        state_next      = FLUSH;
                    end
                end else if (load_use) begin
                    pc_en_int       = 1'b0;
                    if_id_en_int    = 1'b0;
                    id_ex_flush_int = 1'b1;
                end
            end
            MISS_WAIT: begin
                // EX is frozen here, so a held br_taken is serviced once back in RUN
                pc_en_int    = 1'b0;
                if_id_en_int = 1'b0;
                id_ex_en_int = 1'b0;
                pending_next = (pending_reg | miss) & ~fill_done;
                if (pending_next == '0) begin
                    state_next = RUN;
                end
            end
            FLUSH: begin
                if (|miss) begin
                    pc_en_int    = 1'b0;
                    if_id_en_int = 1'b0;
                    id_ex_en_int = 1'b0;
                    pending_next = miss;
                    state_next   = MISS_WAIT;
                end else begin
                    if_id_flush_int = 1'b1;
                    if (flush_left_reg == 2'd0) begin
                        state_next = RUN;
                    end else begin
                        flush_left_next = flush_left_reg - 2'd1;
                    end
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= RUN;
            pending_reg    <= '0;
            flush_left_reg <= 2'd0;
        end else begin
            state_reg      <= state_next;
            pending_reg    <= pending_next;
            flush_left_reg <= flush_left_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (!pc_en_int && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    // Reset overrides the pipeline controls so nothing advances while rst_n is low
    assign pc_en       = rst_n & pc_en_int;
    assign if_id_en    = rst_n & if_id_en_int;
    assign id_ex_en    = rst_n & id_ex_en_int;
    assign if_id_flush = ~rst_n | if_id_flush_int;
    assign id_ex_flush = ~rst_n | id_ex_flush_int;
    assign miss_busy   = rst_n & (state_reg == MISS_WAIT);
    assign pending     = rst_n ? pending_reg : '0;
    assign stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized self-checking bench for pipe_hazard_ctrl against a behavioural model,
// plus directed load-use, dual-miss, saturation and reset-mid-miss scenarios.
module tb_pipe_hazard_ctrl;

    localparam int MS    = 2;
    localparam int FS    = 3;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   id_instr;
    logic          id_valid, ex_valid, ex_is_load, br_taken;
    logic [4:0]    ex_rd;
    logic [MS-1:0] miss, fill_done;
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, miss_busy;
    logic [MS-1:0] pending;
    logic [CW-1:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_hazard_ctrl #(.MISS_SRCS(MS), .FLUSH_SLOTS(FS), .LOAD_USE_EN(1), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .br_taken(br_taken),
        .miss(miss), .fill_done(fill_done), .pc_en(pc_en), .if_id_en(if_id_en),
        .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .miss_busy(miss_busy), .pending(pending), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = running, 1 = waiting on fills, 2 = extra IF/ID bubbles.
    int      m_mode;
    int      m_bubbles;      // IF/ID bubbles still owed after the resolve cycle
    bit [MS-1:0] m_pend;
    int      m_cnt;
    bit      e_pc, e_ifen, e_ifflush, e_idexen, e_idexflush;
    int      n_mode, n_bubbles;
    bit [MS-1:0] n_pend;

    function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
        bit s1, s2;
        case (ins[6:0])
            7'b0110011, 7'b1100011, 7'b0100011: begin s1 = 1; s2 = 1; end
            7'b0010011, 7'b0000011, 7'b1100111: begin s1 = 1; s2 = 0; end
            default:                            begin s1 = 0; s2 = 0; end
        endcase
        return (s1 && ins[19:15] == r) || (s2 && ins[24:20] == r);
    endfunction

    task automatic model_eval();
        e_pc = 1; e_ifen = 1; e_idexen = 1; e_ifflush = 0; e_idexflush = 0;
        n_mode = m_mode; n_bubbles = m_bubbles; n_pend = m_pend;
        if (m_mode == 1) begin
            {e_pc, e_ifen, e_idexen} = 3'b000;
            n_pend = (m_pend | miss) & ~fill_done;
            n_mode = (n_pend == 0) ? 0 : 1;
        end else if (miss != 0) begin
            {e_pc, e_ifen, e_idexen} = 3'b000;
            n_pend = miss;
            n_mode = 1;
        end else if (m_mode == 2) begin
            e_ifflush = 1;
            n_bubbles = m_bubbles - 1;
            n_mode = (n_bubbles == 0) ? 0 : 2;
        end else if (br_taken) begin
            e_ifflush = 1; e_idexflush = 1;
            n_bubbles = FS - 1;
            n_mode = (n_bubbles > 0) ? 2 : 0;
        end else if (id_valid && ex_valid && ex_is_load && ex_rd != 0 && reads_reg(id_instr, ex_rd)) begin
            e_pc = 0; e_ifen = 0; e_idexflush = 1;
        end
    endtask

    // Compare this cycle's combinational outputs, then clock the DUT and the model.
    task automatic step();
        #1;
        model_eval();
        check_val("pc_en", 32'(pc_en), 32'(e_pc));
        check_val("if_id_en", 32'(if_id_en), 32'(e_ifen));
        check_val("id_ex_en", 32'(id_ex_en), 32'(e_idexen));
        check_val("if_id_flush", 32'(if_id_flush), 32'(e_ifflush));
        check_val("id_ex_flush", 32'(id_ex_flush), 32'(e_idexflush));
        check_val("miss_busy", 32'(miss_busy), 32'(m_mode == 1));
        check_val("pending", 32'(pending), 32'(m_pend));
        check_val("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        @(posedge clk);
        if (!e_pc && m_cnt < CMAX) m_cnt++;
        m_mode = n_mode; m_bubbles = n_bubbles; m_pend = n_pend;
        #1;
    endtask

    task automatic clear_inputs();
        id_instr = 32'h0000_0013; id_valid = 0; ex_valid = 0; ex_is_load = 0;
        ex_rd = 0; br_taken = 0; miss = 0; fill_done = 0;
    endtask

    // Asynchronous reset asserted mid-cycle; forced outputs checked before any edge.
    task automatic do_reset();
        rst_n = 0;
        #1;
        check_val("rst_pc_en", 32'(pc_en), 32'd0);
        check_val("rst_if_id_en", 32'(if_id_en), 32'd0);
        check_val("rst_id_ex_en", 32'(id_ex_en), 32'd0);
        check_val("rst_if_id_flush", 32'(if_id_flush), 32'd1);
        check_val("rst_id_ex_flush", 32'(id_ex_flush), 32'd1);
        check_val("rst_miss_busy", 32'(miss_busy), 32'd0);
        check_val("rst_pending", 32'(pending), 32'd0);
        check_val("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        m_mode = 0; m_bubbles = 0; m_pend = 0; m_cnt = 0;
        clear_inputs();
        @(posedge clk);
        #3;
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    logic [MS-1:0] miss_lvl;
    logic [6:0]    ops [8];

    initial begin
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b1100011;
        ops[4] = 7'b0100011; ops[5] = 7'b1100111; ops[6] = 7'b1101111; ops[7] = 7'b0110111;
        clear_inputs();
        rst_n = 1;
        #2;
        do_reset();

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID
        ex_valid = 1; ex_is_load = 1; ex_rd = 5'd5; id_valid = 1;
        id_instr = {7'd0, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011};
        #1;
        check_val("lu_pc_en", 32'(pc_en), 32'd0);
        check_val("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
        step();
        ex_is_load = 0;
        step();
        check_val("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        ex_is_load = 1; ex_rd = 5'd0; id_instr = {7'd0, 5'd0, 5'd0, 3'd0, 5'd6, 7'b0110011};
        #1;
        check_val("lu_x0_pc_en", 32'(pc_en), 32'd1);
        step();
        clear_inputs();

        // Taken branch: three IF/ID bubbles, one ID/EX bubble
        br_taken = 1;
        step();
        br_taken = 0;
        for (int i = 0; i < 4; i++) step();

        // Dual miss: fills at cycles 4 and 9, PC resumes at cycle 10
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            miss      = (c <= 4) ? 2'b11 : 2'b10;
            fill_done = (c == 4) ? 2'b01 : (c == 9) ? 2'b10 : 2'b00;
            step();
            if (c == 4) check_val("dm_pending_c4", 32'(pending), 32'h2);
        end
        miss = 0; fill_done = 0;
        #1;
        check_val("dm_pc_en_c10", 32'(pc_en), 32'd1);
        check_val("dm_stall_cnt", 32'(stall_cnt), 32'd10);
        step();

        // Miss together with a held branch: wait first, flush on return
        miss = 2'b01; br_taken = 1;
        step();
        miss = 0; fill_done = 2'b01;
        step();
        fill_done = 0;
        #1;
        check_val("mb_flush_after", 32'(id_ex_flush), 32'd1);
        step();
        br_taken = 0;
        for (int i = 0; i < 3; i++) step();

        // Saturation, then reset while still waiting on port 0
        do_reset();
        miss = 2'b01;
        for (int i = 0; i < 20; i++) step();
        check_val("sat_stall_cnt", 32'(stall_cnt), 32'(CMAX));
        miss = 0;
        step();
        do_reset();
        #1;
        check_val("post_rst_pc_en", 32'(pc_en), 32'd1);
        check_val("post_rst_busy", 32'(miss_busy), 32'd0);

        // Randomized traffic
        miss_lvl = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                miss_lvl = 0;
            end
            for (int p = 0; p < MS; p++) if (fill_done[p]) miss_lvl[p] = 1'b0;
            fill_done = 0;
            for (int p = 0; p < MS; p++) begin
                if (miss_lvl[p]) begin
                    if ($urandom_range(0, 5) == 0) fill_done[p] = 1'b1;
                end else begin
                    if ($urandom_range(0, 24) == 0) miss_lvl[p] = 1'b1;
                    else if ($urandom_range(0, 29) == 0) fill_done[p] = 1'b1;
                end
            end
            miss       = miss_lvl;
            br_taken   = ($urandom_range(0, 9) == 0);
            id_valid   = ($urandom_range(0, 7) != 0);
            ex_valid   = ($urandom_range(0, 7) != 0);
            ex_is_load = ($urandom_range(0, 2) == 0);
            ex_rd      = 5'($urandom_range(0, 7));
            id_instr   = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          3'($urandom), 5'($urandom), ops[$urandom_range(0, 7)]};
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
